// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared constants and helpers for the counter bank.
//   DEFAULT_WIDTH    - default counter width in bits
//   DEFAULT_CHANNELS - default number of independent counters
//   RD_SEL_W         - width of the read channel select
//   chan_op_e        - per-edge action taken by one channel
//   chan_op()        - resolves clear/enable priority into a chan_op_e
package counter_bank_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_CHANNELS = 4;
  localparam int unsigned RD_SEL_W         = 4;

  typedef enum logic [1:0] {
    CHAN_HOLD  = 2'd0,
    CHAN_CLEAR = 2'd1,
    CHAN_INC   = 2'd2
  } chan_op_e;

  // Clear beats enable, so clear+enable in one cycle lands on zero.
  function automatic chan_op_e chan_op(input logic clear, input logic enable);
    if (clear)       return CHAN_CLEAR;
    else if (enable) return CHAN_INC;
    else             return CHAN_HOLD;
  endfunction

endpackage

// File: rtl/counter_chan.sv
// counter_chan: one wrapping counter with a sticky overflow flag.
// Ports:
//   clk_in         - clock, rising edge
//   reset          - synchronous active-high reset (count and flag to 0)
//   enable         - increment this cycle
//   clear          - zero the count (flag untouched), wins over enable
//   clear_overflow - clear the sticky flag (count untouched)
//   count          - live count
//   overflow       - sticky wrap flag
module counter_chan
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  chan_op_e         op;

  always_comb begin
    op         = chan_op(clear, enable);
    count_d    = count_q;
    overflow_d = overflow_q;
    // Flag clear is applied first so a wrap on the same edge re-sets it.
    if (clear_overflow) overflow_d = 1'b0;
    unique case (op)
      CHAN_CLEAR: count_d = '0;
      CHAN_INC: begin
        count_d = count_q + WIDTH'(1);
        if (count_q == '1) overflow_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: bank of CHANNELS independent WIDTH-bit counters with a
// one-cycle-latency registered read port.
// Optional feature macro: COUNTER_BANK_SNAPSHOT_EN adds the snapshot input and
// shadow registers; reads then return shadow values instead of live counts.
// Ports:
//   clk_in, reset        - clock (rising edge), synchronous active-high reset
//   enable/clear/clear_overflow [CHANNELS] - per-channel controls
//   snapshot             - copy all live counts into shadows (macro only)
//   rd_req, rd_sel       - read request and channel index
//   count [CHANNELS*WIDTH] - live counts, channel i at [i*WIDTH +: WIDTH]
//   overflow [CHANNELS]  - sticky wrap flags
//   rd_data, rd_valid    - registered read result and one-cycle qualifier
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       clear_overflow,
`ifdef COUNTER_BANK_SNAPSHOT_EN
  input  logic                      snapshot,
`endif
  input  logic                      rd_req,
  input  logic [RD_SEL_W-1:0]       rd_sel,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       overflow,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    counter_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_in        (clk_in),
      .reset         (reset),
      .enable        (enable[g]),
      .clear         (clear[g]),
      .clear_overflow(clear_overflow[g]),
      .count         (count[g*WIDTH +: WIDTH]),
      .overflow      (overflow[g])
    );
  end

  logic [WIDTH-1:0] rd_src [CHANNELS];

`ifdef COUNTER_BANK_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = snapshot ? count[i*WIDTH +: WIDTH] : shadow_q[i];
      // Reads see the pre-edge shadow, so a same-edge snapshot is only
      // visible from the following request.
      rd_src[i]   = shadow_q[i];
    end
  end

  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (reset) shadow_q[i] <= '0;
      else       shadow_q[i] <= shadow_d[i];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rd_src[i] = count[i*WIDTH +: WIDTH];
    end
  end
`endif

  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rd_sel == RD_SEL_W'(i)) rd_mux = rd_src[i];
    end
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: randomized and directed stimulus for counter_bank
// (WIDTH=8, CHANNELS=4) with a scoreboard for read responses and a
// behavioural model for counts and overflow flags.
module tb_counter_bank;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk_in = 1'b0;
  logic           reset = 1'b1;
  logic [C-1:0]   enable = '0;
  logic [C-1:0]   clear = '0;
  logic [C-1:0]   clear_overflow = '0;
  logic           snapshot = 1'b0;
  logic           rd_req = 1'b0;
  logic [3:0]     rd_sel = '0;
  logic [C*W-1:0] count;
  logic [C-1:0]   overflow;
  logic [W-1:0]   rd_data;
  logic           rd_valid;

  counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .clear_overflow(clear_overflow),
`ifdef COUNTER_BANK_SNAPSHOT_EN
    .snapshot      (snapshot),
`endif
    .rd_req        (rd_req),
    .rd_sel        (rd_sel),
    .count         (count),
    .overflow      (overflow),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: post-edge state of the bank.
  int unsigned m_cnt [C];
  bit          m_ovf [C];
  int unsigned m_shadow [C];
  int unsigned m_last;
  int unsigned exp_q [$];

  int checks = 0;
  int errors = 0;
  bit done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model across the coming edge.
  task automatic step(input bit rst, input logic [C-1:0] en, input logic [C-1:0] clr,
                      input logic [C-1:0] co, input bit rq, input logic [3:0] sel,
                      input bit snap);
    int unsigned rv;
    @(negedge clk_in);
    #1;
    reset = rst; enable = en; clear = clr; clear_overflow = co;
    rd_req = rq; rd_sel = sel; snapshot = snap;
    if (rst) begin
      for (int i = 0; i < C; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_shadow[i] = 0;
      end
      m_last = 0;
      return;
    end
    if (rq) begin
      rv = 0;
      if (sel < C) begin
`ifdef COUNTER_BANK_SNAPSHOT_EN
        rv = m_shadow[sel];
`else
        rv = m_cnt[sel];
`endif
      end
      exp_q.push_back(rv);
      m_last = rv;
    end
`ifdef COUNTER_BANK_SNAPSHOT_EN
    if (snap) for (int i = 0; i < C; i++) m_shadow[i] = m_cnt[i];
`endif
    for (int i = 0; i < C; i++) begin
      if (co[i]) m_ovf[i] = 0;
      if (clr[i]) m_cnt[i] = 0;
      else if (en[i]) begin
        if (m_cnt[i] == 255) m_ovf[i] = 1;
        m_cnt[i] = (m_cnt[i] + 1) % 256;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, '0, 0, 4'd0, 0);
  endtask

  // Monitor: compares live state every cycle, pops the scoreboard on rd_valid.
  initial begin
    int unsigned e;
    for (int i = 0; i < C; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_shadow[i] = 0;
    end
    m_last = 0;
    forever begin
      @(negedge clk_in);
      if (done) break;
      for (int i = 0; i < C; i++) begin
        check($sformatf("count[%0d]", i), 32'(count[i*W +: W]), m_cnt[i]);
        check($sformatf("overflow[%0d]", i), 32'(overflow[i]), 32'(m_ovf[i]));
      end
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_valid_spurious", 32'(rd_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), e);
        end
      end else begin
        check("rd_valid_missing", 32'(exp_q.size()), 32'd0);
        check("rd_data_hold", 32'(rd_data), m_last);
      end
    end
  end

  initial begin
    logic [C-1:0] en, clr, co;
    logic [3:0]   sel;
    bit           rst, rq, snap;

    // Reset, then ch0 counts for 5 cycles.
    step(1, '0, '0, '0, 0, 4'd0, 0);
    for (int k = 0; k < 5; k++) step(0, 4'b0001, '0, '0, 0, 4'd0, 0);
    @(posedge clk_in); #1;
    check("dir_ch0_eq5", 32'(count[0 +: W]), 32'h05);
    check("dir_ch1_zero", 32'(count[W +: W]), 32'h00);
    check("dir_ovf_zero", 32'(overflow), 32'h0);

    // Bring ch2 to FF, ch1 to 10, ch3 to 22.
    step(1, '0, '0, '0, 0, 4'd0, 0);
    for (int k = 0; k < 255; k++)
      step(0, {(k < 34) ? 1'b1 : 1'b0, 1'b1, (k < 16) ? 1'b1 : 1'b0, 1'b0}, '0, '0, 0, 4'd0, 0);
    // Wrap with coincident flag clear; clear+enable on ch1; read ch3 while counting.
    step(0, 4'b1110, 4'b0010, 4'b0100, 1, 4'd3, 0);
    @(posedge clk_in); #1;
    check("dir_ch2_wrap", 32'(count[2*W +: W]), 32'h00);
    check("dir_ovf2_set_wins", 32'(overflow[2]), 32'h1);
    check("dir_ch1_clr_en", 32'(count[W +: W]), 32'h00);
    check("dir_ovf1_unchanged", 32'(overflow[1]), 32'h0);
    check("dir_ch3_inc", 32'(count[3*W +: W]), 32'h23);
    check("dir_rd_ch3", 32'(rd_data), 32'h22);
    check("dir_rd_valid", 32'(rd_valid), 32'h1);
    step(0, '0, '0, 4'b0100, 1, 4'd7, 0);
    @(posedge clk_in); #1;
    check("dir_ovf2_cleared", 32'(overflow[2]), 32'h0);
    check("dir_rd_oob", 32'(rd_data), 32'h00);
    check("dir_rd_oob_valid", 32'(rd_valid), 32'h1);

`ifdef COUNTER_BANK_SNAPSHOT_EN
    step(1, '0, '0, '0, 0, 4'd0, 0);
    for (int k = 0; k < 64; k++) step(0, 4'b0001, '0, '0, 0, 4'd0, 0);
    step(0, 4'b0001, '0, '0, 1, 4'd0, 1);
    for (int k = 0; k < 10; k++) step(0, 4'b0001, '0, '0, 0, 4'd0, 0);
    step(0, 4'b0001, '0, '0, 1, 4'd0, 0);
    @(posedge clk_in); #1;
    check("dir_snapshot_rd", 32'(rd_data), 32'h40);
`endif

    // Randomized traffic, mostly back-to-back reads.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < C; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        clr[i] = ($urandom_range(0, 47) == 0);
        co[i]  = ($urandom_range(0, 15) == 0);
      end
      rq   = ($urandom_range(0, 4) != 0);
      sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
`ifdef COUNTER_BANK_SNAPSHOT_EN
      snap = ($urandom_range(0, 19) == 0);
`else
      snap = 0;
`endif
      step(rst, en, clr, co, rq, sel, snap);
    end

    // Reset while everything is active: read is dropped, all state zero.
    step(0, 4'b1111, '0, '0, 1, 4'd1, 0);
    step(1, 4'b1111, 4'b0000, 4'b0000, 1, 4'd2, 1);
    @(posedge clk_in); #1;
    check("dir_rst_count", 32'(count), 32'h0);
    check("dir_rst_ovf", 32'(overflow), 32'h0);
    check("dir_rst_rd_valid", 32'(rd_valid), 32'h0);
    check("dir_rst_rd_data", 32'(rd_data), 32'h0);

    idle(3);
    @(negedge clk_in); #2;
    done = 1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter WIDTH, default 32: counter width in bits, legal range 2..32.
REQ-002 Parameter CHANNELS, default 4: number of independent counters, legal range 1..16.
REQ-003 Port clk_in  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port enable  input  CHANNELS: per-channel count-enable; bit i increments channel i.
REQ-006 Port clear  input  CHANNELS: per-channel synchronous zero of count (overflow untouched).
REQ-007 Port clear_overflow  input  CHANNELS: per-channel clear of sticky overflow flag.
REQ-008 Port count  output  CHANNELS*WIDTH: live counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-009 Port overflow  output  CHANNELS: sticky per-channel wrap flags.
REQ-010 Port rd_req  input  1: single-cycle read request for channel rd_sel.
REQ-011 Port rd_sel  input  4: channel index for read; sampled with rd_req.
REQ-012 Port rd_data  output  WIDTH: registered read result.
REQ-013 Port rd_valid  output  1: one-cycle pulse qualifying rd_data.
REQ-014 Port snapshot  input  1: freeze all live counts into shadow registers (present only with COUNTER_BANK_SNAPSHOT_EN).

Function
REQ-015 Per channel, priority per edge SHALL be reset > clear > enable; disabled channel holds value.
REQ-016 Enabled channel at all-ones SHALL wrap to 0 and set overflow[i] on the same edge.
REQ-017 overflow[i] SHALL stay set until clear_overflow[i] or reset; if wrap and clear_overflow[i] coincide, set wins (flag = 1).
REQ-018 clear[i] with enable[i] in same cycle SHALL yield count 0, not 1; no overflow set.
REQ-019 clear_overflow[i] SHALL not modify count[i].
REQ-020 Channels SHALL be fully independent; no cross-channel carry or interaction.
REQ-021 Read latency SHALL be exactly 1 cycle: rd_req at edge N -> rd_valid=1 and rd_data valid after edge N, for one cycle.
REQ-022 rd_data SHALL return the count value as held before edge N (pre-increment value of that cycle).
REQ-023 Back-to-back rd_req every cycle SHALL be supported; rd_valid stays high continuously.
REQ-024 rd_sel >= CHANNELS SHALL return rd_data = 0 with rd_valid = 1.
REQ-025 rd_req asserted with reset SHALL be ignored (rd_valid = 0 next cycle).
REQ-026 When rd_valid = 0, rd_data SHALL hold its last value.

Reset
REQ-027 On reset: all count = 0, overflow = 0, rd_valid = 0, rd_data = 0, shadow registers = 0.
REQ-028 Reset asserted mid-count SHALL take effect at the next edge regardless of enable/clear/rd_req/snapshot.

Configuration
REQ-029 Macro COUNTER_BANK_SNAPSHOT_EN defined: snapshot port exists; snapshot at edge N copies all pre-edge counts into shadows; reads return shadow values instead of live counts.
REQ-030 With COUNTER_BANK_SNAPSHOT_EN defined, snapshot and rd_req at same edge SHALL return the previous shadow value; new shadow visible from next rd_req.
REQ-031 Macro undefined: no snapshot port, no shadow registers; reads return live counts per REQ-022.

Structure
REQ-032 Shared package counter_bank_pkg SHALL hold default WIDTH/CHANNELS constants and the rd_sel width constant (4).
REQ-033 One sub-module counter_chan SHALL implement a single channel (count, overflow, priority logic), instantiated CHANNELS times via generate.
REQ-034 Read mux, rd_valid pipeline register and shadow registers SHALL reside in counter_bank top.

Verification (WIDTH=8, CHANNELS=4 unless noted)
REQ-035 Reset then enable=4'b0001 for 5 cycles -> count ch0=5, ch1..3=0, overflow=0.
REQ-036 Ch2 at 8'hFF, enable[2]=1 and clear_overflow[2]=1 same cycle -> count ch2=0, overflow[2]=1; clear_overflow[2] alone next cycle -> overflow[2]=0.
REQ-037 Ch1 at 8'h10, clear[1]=1 and enable[1]=1 -> count ch1=0; overflow[1] unchanged.
REQ-038 Ch3=8'h22 enabled, rd_req=1 rd_sel=3 -> next cycle rd_valid=1, rd_data=8'h22, count ch3=8'h23; rd_sel=7 -> rd_data=0, rd_valid=1.
REQ-039 SNAPSHOT_EN: ch0=8'h40 counting, snapshot pulse, 10 cycles later rd_req rd_sel=0 -> rd_data=8'h40.
REQ-040 Reset asserted while all channels enabled and rd_req=1 -> next cycle all count=0, overflow=0, rd_valid=0.
